// File: rtl/ccd_readout_seq.sv
// Frame readout sequencer for the KAF CCD: drives V/H/RG clocks, runs the ADC
// sample/busy handshake per pixel and writes each pixel LSB-first as two bytes to the tx FIFO.
module ccd_readout_seq #(
   parameter int ROWS   = 4,
   parameter int COLS   = 8,
   parameter int V_HALF = 16,
   parameter int H_HALF = 4,
   parameter int RG_W   = 2,
   parameter int ADC_W  = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             frame_done,
   output logic             ccd_v1,
   output logic             ccd_v2,
   output logic             ccd_h1,
   output logic             ccd_h2,
   output logic             ccd_rg,
   output logic             adc_sample,
   input  logic             adc_busy,
   input  logic [ADC_W-1:0] adc_data,
   output logic [7:0]       fifo_wdata,
   output logic             fifo_winc,
   input  logic             fifo_wfull
);

   localparam int PH_MAX0 = (V_HALF > H_HALF) ? V_HALF : H_HALF;
   localparam int PH_MAX  = (PH_MAX0 > RG_W) ? PH_MAX0 : RG_W;
   localparam int PH_W    = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
   localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1;

   typedef enum logic [3:0] {
      S_IDLE, S_V1, S_V2, S_RG, S_H1, S_H2,
      S_ADC_REQ, S_ADC_WAIT, S_WR_LO, S_WR_HI, S_DONE
   } state_t;

   state_t            r_state;
   logic [PH_W-1:0]   r_ph;
   logic [ROW_W-1:0]  r_row;
   logic [COL_W-1:0]  r_col;
   logic [ADC_W-1:0]  r_pix;
   logic              r_busy;
   logic              r_frame_done;
   logic              r_v1, r_v2, r_h1, r_h2, r_rg;
   logic              r_adc_sample;

   logic              w_in_wr;
   logic              w_winc;
   logic [ADC_W-1:0]  w_pix_hi;

   // The write strobe is gated by rst so no byte can land in the cycle reset is sampled.
   assign w_in_wr  = (r_state == S_WR_LO) || (r_state == S_WR_HI);
   assign w_winc   = w_in_wr & ~fifo_wfull & ~rst;
   assign w_pix_hi = r_pix >> 8;

   assign fifo_winc  = w_winc;
   assign fifo_wdata = (r_state == S_WR_LO) ? r_pix[7:0] :
                       (r_state == S_WR_HI) ? w_pix_hi[7:0] : 8'h00;

   assign busy       = r_busy;
   assign frame_done = r_frame_done;
   assign ccd_v1     = r_v1;
   assign ccd_v2     = r_v2;
   assign ccd_h1     = r_h1;
   assign ccd_h2     = r_h2;
   assign ccd_rg     = r_rg;
   assign adc_sample = r_adc_sample;

   always_ff @(posedge clk) begin : fsm
      state_t          v_next;
      logic [PH_W-1:0] v_last;
      // NOTE: v_next/v_last are per-cycle temporaries, fully assigned before use, so
      // blocking '=' is correct for them; every stored register still uses '<='.
      v_next = r_state;
      case (r_state)
         S_V1, S_V2: v_last = PH_W'(V_HALF - 1);
         S_RG:       v_last = PH_W'(RG_W - 1);
         default:    v_last = PH_W'(H_HALF - 1);
      endcase

      if (rst) begin
         v_next = S_IDLE;
         r_ph   <= '0;
         r_row  <= '0;
         r_col  <= '0;
         r_pix  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_ph <= '0;
               if (start) begin
                  v_next = S_V1;
                  r_row  <= '0;
                  r_col  <= '0;
               end
            end
            S_V1, S_V2, S_RG, S_H1, S_H2: begin
               if (r_ph == v_last) begin
                  r_ph <= '0;
                  case (r_state)
                     S_V1:    v_next = S_V2;
                     S_V2:    v_next = S_RG;
                     S_RG:    v_next = S_H1;
                     S_H1:    v_next = S_H2;
                     default: v_next = S_ADC_REQ;
                  endcase
               end else begin
                  r_ph <= r_ph + PH_W'(1);
               end
            end
            S_ADC_REQ: begin
               if (adc_busy) v_next = S_ADC_WAIT;
            end
            S_ADC_WAIT: begin
               if (!adc_busy) begin
                  r_pix  <= adc_data;
                  v_next = S_WR_LO;
               end
            end
            S_WR_LO: begin
               if (w_winc) v_next = S_WR_HI;
            end
            S_WR_HI: begin
               if (w_winc) begin
                  if (r_col != COL_W'(COLS - 1)) begin
                     r_col  <= r_col + COL_W'(1);
                     v_next = S_RG;
                  end else if (r_row != ROW_W'(ROWS - 1)) begin
                     r_col  <= '0;
                     r_row  <= r_row + ROW_W'(1);
                     v_next = S_V1;
                  end else begin
                     v_next = S_DONE;
                  end
               end
            end
            S_DONE:  v_next = S_IDLE;
            default: v_next = S_IDLE;
         endcase
      end

      // Outputs are decoded from the state being entered, so they are true flops aligned to it.
      r_state      <= v_next;
      r_busy       <= (v_next != S_IDLE);
      r_frame_done <= (v_next == S_DONE);
      r_v1         <= (v_next == S_V1);
      r_v2         <= (v_next == S_V2);
      r_rg         <= (v_next == S_RG);
      r_h1         <= (v_next == S_H1);
      r_h2         <= (v_next == S_H2);
      r_adc_sample <= (v_next == S_ADC_REQ);
   end

endmodule

// File: tb/tb_ccd_readout_seq.sv
// Self-checking bench for ccd_readout_seq: ADC responder, FIFO byte monitor and
// clock-shape monitor, compared against a frame model built from the pixel values handed out.
module tb_ccd_readout_seq;

   localparam int ROWS   = 2;
   localparam int COLS   = 3;
   localparam int V_HALF = 4;
   localparam int H_HALF = 2;
   localparam int RG_W   = 1;
   localparam int ADC_W  = 10;
   localparam int NPIX   = ROWS * COLS;

   typedef enum int {M_BASIC, M_BP, M_START, M_SLOW, M_RANDOM} mode_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             busy;
   logic             frame_done;
   logic             ccd_v1, ccd_v2, ccd_h1, ccd_h2, ccd_rg;
   logic             adc_sample;
   logic             adc_busy;
   logic [ADC_W-1:0] adc_data;
   logic [7:0]       fifo_wdata;
   logic             fifo_winc;
   logic             fifo_wfull;

   always #5 clk = ~clk;

   ccd_readout_seq #(
      .ROWS(ROWS), .COLS(COLS), .V_HALF(V_HALF), .H_HALF(H_HALF), .RG_W(RG_W), .ADC_W(ADC_W)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .frame_done(frame_done),
      .ccd_v1(ccd_v1), .ccd_v2(ccd_v2), .ccd_h1(ccd_h1), .ccd_h2(ccd_h2), .ccd_rg(ccd_rg),
      .adc_sample(adc_sample), .adc_busy(adc_busy), .adc_data(adc_data),
      .fifo_wdata(fifo_wdata), .fifo_winc(fifo_winc), .fifo_wfull(fifo_wfull)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- ADC responder ----------------
   logic [ADC_W-1:0] pix_vals [NPIX];
   int adc_b       = 5;
   int adc_rise    = 0;
   int adc_idx     = 0;
   int adc_serving = -1;

   initial begin : adc_model
      int cur;
      adc_busy = 1'b0;
      adc_data = '0;
      forever begin
         @(posedge clk); #1;
         if (adc_sample && !adc_busy) begin
            cur = adc_idx;
            for (int i = 0; i < adc_rise; i++) begin
               @(posedge clk); #1;
               check("adc_sample_hold", 32'(adc_sample), 32'd1);
            end
            adc_serving = cur;
            adc_busy    = 1'b1;
            repeat (adc_b) begin @(posedge clk); #1; end
            adc_data = (cur < NPIX) ? pix_vals[cur] : '0;
            adc_idx  = cur + 1;
            adc_busy = 1'b0;
         end
      end
   end

   // ---------------- Monitors ----------------
   logic [7:0] got_q [$];
   int done_cnt = 0, busy_after_done = 0, done_not_busy = 0, overlap_cnt = 0;
   int pulses  [5] = '{default: 0};
   int bad_w   [5] = '{default: 0};
   int run_len [5] = '{default: 0};
   logic prev_done = 1'b0;
   // index 0..4 = rg, h2, h1, v2, v1
   int exp_w   [5] = '{RG_W, H_HALF, H_HALF, V_HALF, V_HALF};
   int exp_np  [5] = '{NPIX, NPIX, NPIX, ROWS, ROWS};
   string ccd_name [5] = '{"rg", "h2", "h1", "v2", "v1"};

   always @(negedge clk) begin : mon
      logic [4:0] ccd;
      ccd = {ccd_v1, ccd_v2, ccd_h1, ccd_h2, ccd_rg};
      if (fifo_winc) got_q.push_back(fifo_wdata);
      if (frame_done) done_cnt++;
      if (frame_done && !busy) done_not_busy++;
      if (prev_done && busy) busy_after_done++;
      prev_done = frame_done;
      if ($countones(ccd) > 1) overlap_cnt++;
      for (int i = 0; i < 5; i++) begin
         if (ccd[i]) run_len[i]++;
         else if (run_len[i] > 0) begin
            pulses[i]++;
            if (run_len[i] != exp_w[i]) bad_w[i]++;
            run_len[i] = 0;
         end
      end
   end

   task automatic load_fixed();
      logic [ADC_W-1:0] fixed_vals [NPIX];
      fixed_vals = '{10'h155, 10'h2AA, 10'h3FF, 10'h001, 10'h100, 10'h0FF};
      for (int i = 0; i < NPIX; i++) pix_vals[i] = fixed_vals[i];
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic run_frame(input mode_t mode);
      int base_b, base_d, base_bad, base_dnb, base_ov;
      int p0 [5];
      int w0 [5];
      logic [15:0] v;
      if (mode == M_RANDOM) begin
         for (int i = 0; i < NPIX; i++) pix_vals[i] = ADC_W'($urandom);
         adc_b    = $urandom_range(1, 7);
         adc_rise = $urandom_range(0, 3);
      end else begin
         load_fixed();
         adc_b    = 5;
         adc_rise = (mode == M_SLOW) ? 20 : 0;
      end
      adc_idx  = 0;
      base_b   = got_q.size();
      base_d   = done_cnt;
      base_bad = busy_after_done;
      base_dnb = done_not_busy;
      base_ov  = overlap_cnt;
      for (int i = 0; i < 5; i++) begin p0[i] = pulses[i]; w0[i] = bad_w[i]; end

      pulse_start();
      check("start_busy", 32'(busy), 32'd1);
      check("start_v1", 32'(ccd_v1), 32'd1);

      fork
         begin
            int c = 0;
            while (done_cnt == base_d && c < 4000) begin @(posedge clk); #1; c++; end
            check("frame_timeout", 32'(done_cnt != base_d), 32'd1);
         end
         begin
            case (mode)
               M_BP: begin
                  int k = 0;
                  while (got_q.size() < base_b + 3 && k < 4000) begin @(posedge clk); #2; k++; end
                  check("bp_reach_wr_hi", 32'(got_q.size() >= base_b + 3), 32'd1);
                  fifo_wfull = 1'b1;
                  for (int i = 0; i < 10; i++) begin
                     @(negedge clk);
                     check("bp_stall_winc", 32'(fifo_winc), 32'd0);
                     @(posedge clk); #1;
                  end
                  fifo_wfull = 1'b0;
                  @(negedge clk);
                  check("bp_resume_winc", 32'(fifo_winc), 32'd1);
                  check("bp_resume_byte", 32'(fifo_wdata), 32'h02);
               end
               M_START: begin
                  repeat (60) @(posedge clk);
                  #1 start = 1'b1;
                  @(posedge clk); #1 start = 1'b0;
               end
               M_RANDOM: begin
                  int k = 0;
                  while (done_cnt == base_d && k < 4000) begin
                     @(posedge clk); #1;
                     fifo_wfull = ($urandom_range(0, 3) == 0);
                     k++;
                  end
                  fifo_wfull = 1'b0;
               end
               default: ;
            endcase
         end
      join
      fifo_wfull = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check("busy_idle", 32'(busy), 32'd0);
      check("done_pulses", 32'(done_cnt - base_d), 32'd1);
      check("busy_after_done", 32'(busy_after_done - base_bad), 32'd0);
      check("done_while_busy", 32'(done_not_busy - base_dnb), 32'd0);
      check("byte_count", 32'(got_q.size() - base_b), 32'(2 * NPIX));
      for (int j = 0; j < 2 * NPIX; j++) begin
         if (base_b + j < got_q.size()) begin
            v = 16'(pix_vals[j / 2]);
            check($sformatf("byte%0d", j), 32'(got_q[base_b + j]),
                  32'((j % 2 == 0) ? v[7:0] : v[15:8]));
         end
      end
      for (int i = 0; i < 5; i++) begin
         check({ccd_name[i], "_pulses"}, 32'(pulses[i] - p0[i]), 32'(exp_np[i]));
         check({ccd_name[i], "_width"}, 32'(bad_w[i] - w0[i]), 32'd0);
      end
      check("ccd_overlap", 32'(overlap_cnt - base_ov), 32'd0);
   endtask

   task automatic run_reset_midframe();
      int base_b, base_d, k;
      load_fixed();
      adc_b       = 5;
      adc_rise    = 0;
      adc_idx     = 0;
      adc_serving = -1;
      base_b      = got_q.size();
      base_d      = done_cnt;
      pulse_start();
      k = 0;
      while (!(adc_serving == 4 && adc_busy) && k < 4000) begin @(posedge clk); #2; k++; end
      check("rst_reach_pix4", 32'(adc_serving == 4 && adc_busy), 32'd1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1;
      check("rst_mid_outputs", 32'({busy, frame_done, ccd_v1, ccd_v2, ccd_h1, ccd_h2, ccd_rg,
                                    adc_sample, fifo_winc, fifo_wdata}), 32'd0);
      check("rst_mid_bytes", 32'(got_q.size() - base_b), 32'd8);
      rst = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("rst_idle_busy", 32'(busy), 32'd0);
      check("rst_no_late_write", 32'(got_q.size() - base_b), 32'd8);
      check("rst_no_done", 32'(done_cnt - base_d), 32'd0);
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      rst        = 1'b1;
      start      = 1'b0;
      fifo_wfull = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", 32'({busy, frame_done, ccd_v1, ccd_v2, ccd_h1, ccd_h2, ccd_rg,
                                  adc_sample, fifo_winc, fifo_wdata}), 32'd0);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("idle_no_start", 32'(busy), 32'd0);

      run_frame(M_BASIC);
      run_frame(M_BP);
      run_frame(M_START);
      run_reset_midframe();
      run_frame(M_BASIC);
      run_frame(M_SLOW);
      for (int r = 0; r < 3; r++) run_frame(M_RANDOM);

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
